// File: rtl/io_bus_pkg.sv
// Shared definitions for the peripheral IO bus arbiter: device indices,
// arbiter state encoding and the read pattern returned on a starved access.
package io_bus_pkg;

  localparam logic [1:0] DEV_GPIOS  = 2'd0;
  localparam logic [1:0] DEV_TIMERS = 2'd1;
  localparam logic [1:0] DEV_SERIAL = 2'd2;
  localparam logic [1:0] DEV_SID    = 2'd3;

  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    ACK,
    HOLD
  } state_t;

endpackage

// File: rtl/io_dev_decode.sv
// Device read mux and write-strobe decode for the four IO peripherals.
// The address bits [7:6] select the device; a strobe fires only when the
// path is enabled and the access is a write.
module io_dev_decode
  import io_bus_pkg::*;
(
  input  logic       en,
  input  logic       we,
  input  logic [1:0] dev,
  input  logic [7:0] in_gpios,
  input  logic [7:0] in_timers,
  input  logic [7:0] in_serial_ports,
  input  logic [7:0] in_sid,
  output logic [7:0] rdata,
  output logic [3:0] strobe
);

  // Read mux and one-hot strobe decode.
  always_comb begin
    rdata  = in_gpios;
    strobe = 4'b0000;
    case (dev)
      DEV_GPIOS:  rdata = in_gpios;
      DEV_TIMERS: rdata = in_timers;
      DEV_SERIAL: rdata = in_serial_ports;
      DEV_SID:    rdata = in_sid;
      default:    rdata = in_gpios;
    endcase
    if (en && we) strobe[dev] = 1'b1;
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates the 8-bit peripheral IO bus between the CPU ext IO port and a
// Wishbone host. The CPU cannot stall, so it always wins combinationally.
// A Wishbone request is latched, waits for an idle bus cycle, backs off and
// retries if the CPU reappears in its slot, and answers with all-ones after
// MAX_WAIT busy cycles.
//
// Wishbone handshake: a request is (wbs_cyc_i && wbs_stb_i && wbs_sel_io) in
// IDLE; wbs_ack_o is a single-cycle pulse, after which the arbiter waits for
// the master to drop cyc/stb before it will accept another request.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_io_cyc,
  input  logic        cpu_io_we,
  input  logic [7:0]  cpu_io_addr,
  input  logic [7:0]  cpu_io_wdata,
  output logic [7:0]  cpu_io_rdata,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic        wbs_sel_io,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        bus_cyc,
  output logic [5:0]  bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_we_gpios,
  output logic        bus_we_timers,
  output logic        bus_we_serial_ports,
  output logic        bus_we_sid,
  input  logic [7:0]  bus_in_gpios,
  input  logic [7:0]  bus_in_timers,
  input  logic [7:0]  bus_in_serial_ports,
  input  logic [7:0]  bus_in_sid,
  output logic        wb_grant,
  output logic        wb_timeout_flag
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t            state, state_next;
  logic [WAIT_W-1:0] cnt;
  logic [7:0]        lat_addr;
  logic [7:0]        lat_data;
  logic              lat_we;

  logic              req;
  logic              wb_drive;
  logic              latch_en, cnt_clr, cnt_inc, load_read, load_timeout;
  logic [7:0]        cpu_rd, wb_rd;
  logic [3:0]        cpu_stb, wb_stb, bus_stb;

  // Address/data bits outside the IO byte window are don't-care here.
  logic              unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:10], wbs_adr_i[1:0], wbs_dat_i[31:8]};

  assign req      = wbs_cyc_i && wbs_stb_i;
  assign wb_grant = (state == ACCESS);
  // Wishbone only drives the bus in its granted slot when the CPU is quiet.
  assign wb_drive = wb_grant && !cpu_io_cyc;

  io_dev_decode u_cpu_dec (
    .en              (cpu_io_cyc),
    .we              (cpu_io_we),
    .dev             (cpu_io_addr[7:6]),
    .in_gpios        (bus_in_gpios),
    .in_timers       (bus_in_timers),
    .in_serial_ports (bus_in_serial_ports),
    .in_sid          (bus_in_sid),
    .rdata           (cpu_rd),
    .strobe          (cpu_stb)
  );

  io_dev_decode u_wb_dec (
    .en              (wb_drive),
    .we              (lat_we),
    .dev             (lat_addr[7:6]),
    .in_gpios        (bus_in_gpios),
    .in_timers       (bus_in_timers),
    .in_serial_ports (bus_in_serial_ports),
    .in_sid          (bus_in_sid),
    .rdata           (wb_rd),
    .strobe          (wb_stb)
  );

  assign cpu_io_rdata        = cpu_rd;
  assign bus_stb             = cpu_stb | wb_stb;
  assign bus_we_gpios        = bus_stb[DEV_GPIOS];
  assign bus_we_timers       = bus_stb[DEV_TIMERS];
  assign bus_we_serial_ports = bus_stb[DEV_SERIAL];
  assign bus_we_sid          = bus_stb[DEV_SID];
  assign bus_cyc             = cpu_io_cyc || wb_drive;
  assign bus_addr            = wb_drive ? lat_addr[5:0] : cpu_io_addr[5:0];
  assign bus_data_out        = wb_drive ? lat_data : cpu_io_wdata;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next   = state;
    latch_en     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    load_read    = 1'b0;
    load_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (req && wbs_sel_io) begin
          latch_en   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!cpu_io_cyc) begin
          state_next = ACCESS;
        end else if (cnt == MAX_CNT) begin
          load_timeout = 1'b1;
          state_next   = ACK;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ACCESS: begin
        if (!cpu_io_cyc) begin
          load_read  = 1'b1;
          state_next = ACK;
        end else begin
          cnt_inc    = 1'b1;
          state_next = WAIT;
        end
      end
      ACK:     state_next = HOLD;
      HOLD:    if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and Wishbone response registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt             <= '0;
      lat_addr        <= 8'h00;
      lat_data        <= 8'h00;
      lat_we          <= 1'b0;
      wbs_dat_o       <= 32'h0;
      wbs_ack_o       <= 1'b0;
      wb_timeout_flag <= 1'b0;
    end else begin
      if (latch_en) begin
        lat_addr <= wbs_adr_i[9:2];
        lat_data <= wbs_dat_i[7:0];
        lat_we   <= wbs_we_i;
      end
      // Saturate so a collision on the last allowed cycle cannot wrap.
      if (cnt_clr)                        cnt <= '0;
      else if (cnt_inc && cnt != MAX_CNT) cnt <= cnt + 1'b1;
      if (load_read)    wbs_dat_o <= {24'h0, wb_rd};
      if (load_timeout) begin
        wbs_dat_o       <= TIMEOUT_DATA;
        wb_timeout_flag <= 1'b1;
      end
      wbs_ack_o <= (state_next == ACK);
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter. Each Wishbone transaction runs
// against a per-cycle CPU activity pattern; the expected slot is the first
// cycle (from cycle 2 on) that is idle and follows an idle cycle.
module tb_io_bus_arbiter;

  localparam int PAT_N = 72;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cpu_io_cyc, cpu_io_we;
  logic [7:0]  cpu_io_addr, cpu_io_wdata, cpu_io_rdata;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_io;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic        bus_cyc;
  logic [5:0]  bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_we_gpios, bus_we_timers, bus_we_serial_ports, bus_we_sid;
  logic [7:0]  bus_in_gpios, bus_in_timers, bus_in_serial_ports, bus_in_sid;
  logic        wb_grant, wb_timeout_flag;

  logic [7:0]  bus_in_arr [4];
  logic        cpu_pat      [PAT_N];
  logic        cpu_we_pat   [PAT_N];
  logic [7:0]  cpu_addr_pat [PAT_N];
  logic [7:0]  cpu_data_pat [PAT_N];
  logic        exp_timeout;

  int checks = 0;
  int errors = 0;

  assign bus_in_gpios        = bus_in_arr[0];
  assign bus_in_timers       = bus_in_arr[1];
  assign bus_in_serial_ports = bus_in_arr[2];
  assign bus_in_sid          = bus_in_arr[3];

  io_bus_arbiter #(.MAX_WAIT(255), .WAIT_W(8)) dut (
    .wb_clk_i            (wb_clk_i),
    .wb_rst_i            (wb_rst_i),
    .cpu_io_cyc          (cpu_io_cyc),
    .cpu_io_we           (cpu_io_we),
    .cpu_io_addr         (cpu_io_addr),
    .cpu_io_wdata        (cpu_io_wdata),
    .cpu_io_rdata        (cpu_io_rdata),
    .wbs_cyc_i           (wbs_cyc_i),
    .wbs_stb_i           (wbs_stb_i),
    .wbs_we_i            (wbs_we_i),
    .wbs_sel_io          (wbs_sel_io),
    .wbs_adr_i           (wbs_adr_i),
    .wbs_dat_i           (wbs_dat_i),
    .wbs_dat_o           (wbs_dat_o),
    .wbs_ack_o           (wbs_ack_o),
    .bus_cyc             (bus_cyc),
    .bus_addr            (bus_addr),
    .bus_data_out        (bus_data_out),
    .bus_we_gpios        (bus_we_gpios),
    .bus_we_timers       (bus_we_timers),
    .bus_we_serial_ports (bus_we_serial_ports),
    .bus_we_sid          (bus_we_sid),
    .bus_in_gpios        (bus_in_gpios),
    .bus_in_timers       (bus_in_timers),
    .bus_in_serial_ports (bus_in_serial_ports),
    .bus_in_sid          (bus_in_sid),
    .wb_grant            (wb_grant),
    .wb_timeout_flag     (wb_timeout_flag)
  );

  // Clock.
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] d);
    onehot = 4'b0001 << d;
  endfunction

  function automatic logic [3:0] strobes();
    strobes = {bus_we_sid, bus_we_serial_ports, bus_we_timers, bus_we_gpios};
  endfunction

  task automatic randomize_bus_in();
    for (int i = 0; i < 4; i++) bus_in_arr[i] = 8'($urandom);
  endtask

  task automatic clear_pat();
    for (int t = 0; t < PAT_N; t++) begin
      cpu_pat[t]      = 1'b0;
      cpu_we_pat[t]   = 1'b0;
      cpu_addr_pat[t] = 8'($urandom);
      cpu_data_pat[t] = 8'($urandom);
    end
  endtask

  task automatic fill_random();
    for (int t = 0; t < PAT_N; t++) begin
      cpu_pat[t]      = ($urandom_range(0, 9) < 4);
      cpu_we_pat[t]   = 1'($urandom_range(0, 1));
      cpu_addr_pat[t] = 8'($urandom);
      cpu_data_pat[t] = 8'($urandom);
    end
    // Guarantees an idle pair so every transaction finds a slot.
    cpu_pat[60] = 1'b0;
    cpu_pat[61] = 1'b0;
  endtask

  task automatic set_wb(input logic req);
    wbs_cyc_i  = req;
    wbs_stb_i  = req;
    wbs_sel_io = req;
  endtask

  // One Wishbone transaction issued in cycle 0 against the current CPU pattern.
  task automatic run_txn(input logic [7:0] addr, input logic we, input logic [7:0] data,
                         input int hold);
    int         ta;
    int         tend;
    logic       slot;
    logic [1:0] cdev;
    logic [7:0] caddr;
    logic [3:0] exp_stb;
    ta = -1;
    for (int t = 2; t < PAT_N; t++)
      if (ta < 0 && !cpu_pat[t-1] && !cpu_pat[t]) ta = t;
    tend = ta + 2 + hold;
    for (int t = 0; t <= tend && t < PAT_N; t++) begin
      @(posedge wb_clk_i); #1;
      cpu_io_cyc   = cpu_pat[t];
      cpu_io_we    = cpu_we_pat[t];
      cpu_io_addr  = cpu_addr_pat[t];
      cpu_io_wdata = cpu_data_pat[t];
      set_wb(t <= ta + 1 + hold);
      if (t == 0) begin
        wbs_adr_i      = $urandom;
        wbs_adr_i[9:2] = addr;
        wbs_dat_i      = $urandom;
        wbs_dat_i[7:0] = data;
        wbs_we_i       = we;
      end else begin
        wbs_adr_i = $urandom;
        wbs_dat_i = $urandom;
        wbs_we_i  = 1'($urandom_range(0, 1));
      end
      @(negedge wb_clk_i);
      slot  = (t == ta);
      caddr = cpu_addr_pat[t];
      cdev  = caddr[7:6];
      exp_stb = 4'b0000;
      if (cpu_pat[t] && cpu_we_pat[t]) exp_stb = onehot(cdev);
      if (slot && we) exp_stb = onehot(addr[7:6]);
      check("bus_cyc", bus_cyc, cpu_pat[t] || slot);
      check("bus_addr", bus_addr, slot ? addr[5:0] : caddr[5:0]);
      check("bus_data", bus_data_out, slot ? data : cpu_data_pat[t]);
      check("strobes", strobes(), exp_stb);
      check("ack", wbs_ack_o, t == ta + 1);
      check("cpu_rdata", cpu_io_rdata, bus_in_arr[cdev]);
      check("timeout_flag", wb_timeout_flag, exp_timeout);
      if (slot) check("grant", wb_grant, 1'b1);
      if (t == ta + 1) begin
        check("rd_data", wbs_dat_o, {24'h0, bus_in_arr[addr[7:6]]});
        check("grant_off", wb_grant, 1'b0);
      end
    end
  endtask

  initial begin
    wb_rst_i     = 1'b1;
    cpu_io_cyc   = 1'b0;
    cpu_io_we    = 1'b0;
    cpu_io_addr  = 8'h00;
    cpu_io_wdata = 8'h00;
    wbs_we_i     = 1'b0;
    wbs_adr_i    = 32'h0;
    wbs_dat_i    = 32'h0;
    set_wb(1'b0);
    exp_timeout  = 1'b0;
    randomize_bus_in();

    // Reset state.
    #1;
    check("rst_ack", wbs_ack_o, 1'b0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_grant", wb_grant, 1'b0);
    check("rst_flag", wb_timeout_flag, 1'b0);
    check("rst_bus_cyc", bus_cyc, 1'b0);
    check("rst_strobes", strobes(), 4'b0000);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Uncontended write to timers reg 2.
    clear_pat();
    randomize_bus_in();
    run_txn(8'h42, 1'b1, 8'hA5, 0);

    // Uncontended read of sid reg 5.
    clear_pat();
    bus_in_arr[3] = 8'h3C;
    run_txn(8'hC5, 1'b0, 8'h00, 0);

    // CPU write to gpios reg 1 holds the bus while Wishbone waits.
    clear_pat();
    for (int t = 0; t < 8; t++) begin
      cpu_pat[t] = 1'b1; cpu_we_pat[t] = 1'b1;
      cpu_addr_pat[t] = 8'h01; cpu_data_pat[t] = 8'h77;
    end
    run_txn(8'h81, 1'b1, 8'h5E, 1);

    // CPU appears exactly in the granted slot of a Wishbone write.
    clear_pat();
    cpu_pat[2] = 1'b1; cpu_we_pat[2] = 1'b1;
    cpu_addr_pat[2] = 8'h03; cpu_data_pat[2] = 8'h99;
    run_txn(8'h47, 1'b1, 8'hC1, 0);

    // Randomized contention.
    for (int k = 0; k < 25; k++) begin
      fill_random();
      randomize_bus_in();
      run_txn(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3));
    end

    // Starvation: CPU busy for 300 cycles.
    for (int t = 0; t <= 300; t++) begin
      @(posedge wb_clk_i); #1;
      cpu_io_cyc   = 1'b1;
      cpu_io_we    = 1'b0;
      cpu_io_addr  = 8'($urandom);
      cpu_io_wdata = 8'($urandom);
      set_wb(t <= 257);
      if (t == 0) begin
        wbs_adr_i = 32'h0000_0200;
        wbs_dat_i = 32'h0000_0011;
        wbs_we_i  = 1'b1;
      end
      @(negedge wb_clk_i);
      check("to_ack", wbs_ack_o, t == 257);
      check("to_strobes", strobes(), 4'b0000);
      check("to_bus_cyc", bus_cyc, 1'b1);
      check("to_flag", wb_timeout_flag, t >= 257);
      if (t == 257) check("to_data", wbs_dat_o, 32'hFFFF_FFFF);
    end
    exp_timeout = 1'b1;
    @(posedge wb_clk_i); #1;
    cpu_io_cyc = 1'b0;

    // Flag stays set across a later normal transaction.
    clear_pat();
    randomize_bus_in();
    run_txn(8'h15, 1'b0, 8'h00, 0);
    check("flag_sticky", wb_timeout_flag, 1'b1);

    // Reset asserted while the write is in its granted slot.
    clear_pat();
    @(posedge wb_clk_i); #1;
    cpu_io_cyc = 1'b0;
    set_wb(1'b1);
    wbs_adr_i = 32'h0000_030C;
    wbs_dat_i = 32'h0000_005A;
    wbs_we_i  = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("pre_rst_sid", bus_we_sid, 1'b1);
    check("pre_rst_grant", wb_grant, 1'b1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("mid_rst_strobes", strobes(), 4'b0000);
    check("mid_rst_bus_cyc", bus_cyc, 1'b0);
    check("mid_rst_grant", wb_grant, 1'b0);
    check("mid_rst_ack", wbs_ack_o, 1'b0);
    check("mid_rst_dat", wbs_dat_o, 32'h0);
    check("mid_rst_flag", wb_timeout_flag, 1'b0);
    exp_timeout = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    set_wb(1'b0);
    @(negedge wb_clk_i);
    check("post_rst_ack", wbs_ack_o, 1'b0);
    check("post_rst_bus_cyc", bus_cyc, 1'b0);

    // Normal access after reset, master holds stb high after the ack.
    randomize_bus_in();
    run_txn(8'hC9, 1'b1, 8'h3E, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the internal 8-bit peripheral IO bus between two requesters: the AS2650 core (ext IO port) and a Wishbone host.
- Peripherals on the bus: gpios, timers, serial_ports, sid.
- The CPU cannot be stalled, so it has absolute priority. Wishbone accesses are slotted into idle bus cycles, aborted and retried on collision, and time out if starved.
- Sits in the wrapper between the core, the Wishbone slave decode and the peripheral bus signals.

Parameters:
- MAX_WAIT, 255: Wishbone wait-cycle limit before a timeout response.
- WAIT_W, 8: width of the wait counter; must satisfy MAX_WAIT < 2^WAIT_W.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cpu_io_cyc  in  1  CPU IO cycle active.
- cpu_io_we  in  1  CPU IO write.
- cpu_io_addr  in  8  [7:6] device, [5:0] register.
- cpu_io_wdata  in  8  CPU write data.
- cpu_io_rdata  out  8  read mux output for the CPU, combinational.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control.
- wbs_sel_io  in  1  wrapper decode: this Wishbone cycle targets the IO bus.
- wbs_adr_i  in  32  IO address = wbs_adr_i[9:2].
- wbs_dat_i  in  32  write byte = wbs_dat_i[7:0].
- wbs_dat_o  out  32  registered read data.
- wbs_ack_o  out  1  registered acknowledge.
- bus_cyc  out  1  IO bus cycle active.
- bus_addr  out  6  register address.
- bus_data_out  out  8  write data.
- bus_we_gpios, bus_we_timers, bus_we_serial_ports, bus_we_sid  out  1 each  per-device write strobes.
- bus_in_gpios, bus_in_timers, bus_in_serial_ports, bus_in_sid  in  8 each  per-device read data.
- wb_grant  out  1  Wishbone currently owns the bus (debug).
- wb_timeout_flag  out  1  sticky starvation indicator.

Behaviour:
- Reset (asynchronous, wb_rst_i=1):
  - state=IDLE; wait counter=0.
  - wbs_ack_o=0, wbs_dat_o=0, wb_timeout_flag=0, wb_grant=0.
  - Latched address, data and we = 0.
- Device index: 0 gpios, 1 timers, 2 serial_ports, 3 sid. Strobe for device d = we && index==d.
- CPU path, fully combinational, wins whenever cpu_io_cyc=1:
  - bus_cyc=1, bus_addr=cpu_io_addr[5:0], bus_data_out=cpu_io_wdata.
  - Strobes decoded from cpu_io_we and cpu_io_addr[7:6].
- cpu_io_rdata = read mux on cpu_io_addr[7:6] at all times.
- Bus idle (no CPU cycle, no Wishbone grant): bus_cyc=0, all strobes 0, bus_addr and bus_data_out follow the CPU inputs.
- FSM:
  - IDLE: on wbs_cyc_i && wbs_stb_i && wbs_sel_io, latch wbs_adr_i[9:2], wbs_dat_i[7:0] and wbs_we_i; clear the counter; go to WAIT.
  - WAIT:
    - If cpu_io_cyc=0, go to ACCESS.
    - Else if counter==MAX_WAIT, load wbs_dat_o=32'hFFFFFFFF, set wb_timeout_flag, go to ACK.
    - Else counter+1.
  - ACCESS: wb_grant=1.
    - If cpu_io_cyc=0: bus driven from the latched Wishbone fields (bus_cyc=1, strobe if write); wbs_dat_o <= {24'h0, mux(latched dev)}; go to ACK.
    - If cpu_io_cyc=1 (collision): the CPU drives the bus, no Wishbone strobe is issued, counter+1, go back to WAIT. Timeout is checked there.
  - ACK: wbs_ack_o=1 for exactly one cycle; go to HOLD.
  - HOLD: stay until wbs_cyc_i && wbs_stb_i is low, then go to IDLE. This prevents re-triggering on a slow master.
- Latency without contention: valid seen at edge N, ACCESS in cycle N+2, ack in cycle N+3.
- Write data is presented to the peripheral for exactly one cycle. A write strobe is never issued twice for one Wishbone transaction.
- wb_timeout_flag is sticky; only wb_rst_i clears it. On timeout no bus access occurs.
- wbs_adr_i and wbs_dat_i changing after the IDLE latch has no effect.
- Reset mid-transaction: returns to IDLE immediately, no ack issued, strobes drop asynchronously.

Decomposition:
- Shared package io_bus_pkg:
  - Device index constants DEV_GPIOS=0, DEV_TIMERS=1, DEV_SERIAL=2, DEV_SID=3.
  - FSM state encoding IDLE/WAIT/ACCESS/ACK/HOLD.
  - Read-data timeout pattern 32'hFFFFFFFF.
- Sub-module io_dev_decode: combinational device read mux plus strobe decode. Instantiated twice:
  - CPU read path.
  - Shared bus-strobe / Wishbone read path.

Test Plan:
1. Wishbone write to addr 0x42 (timers reg 2), data 0xA5, CPU idle -> bus_we_timers=1 for one cycle with bus_addr=2 and bus_data_out=0xA5; ack 3 cycles after valid.
2. Wishbone read of sid reg 5 with bus_in_sid=0x3C -> wbs_dat_o=0x0000003C with ack; no strobe asserted.
3. CPU write to gpios reg 1 held while a Wishbone request is pending -> only the CPU strobe fires; Wishbone completes the first cycle cpu_io_cyc drops.
4. cpu_io_cyc rises exactly in the ACCESS cycle of a Wishbone write -> no Wishbone strobe that cycle; exactly one strobe later; CPU data on the bus during the collision.
5. cpu_io_cyc held high for 300 cycles, MAX_WAIT=255 -> ack with 0xFFFFFFFF, wb_timeout_flag=1 and stays set; no peripheral strobe.
6. wb_rst_i asserted while in ACCESS -> outputs zero immediately; after release a new access completes normally and wbs_stb_i held high after ack causes no second access.
